uart_rx_core: RTL and testbench

//  Receive side of the UART: regenerates a 16x oversampling tick from the DLL/DLH divisor,

---
 rtl/uart_rx_core_if.sv | 20 ++
 rtl/uart_rx_core.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Receive-buffer handshake between the UART receiver core and the register block (RBR/LSR).
// The core drives the byte and its status flags; the host returns a one-cycle rx_ack.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       rx_ack;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 16x tick from {dlh,dll}, start/data/stop FSM, byte handed off by valid/ack.
// Parity checking is compiled in only with `define UART_RX_PARITY_EN (else parity_err is tied 0).
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic           clk_cpu,
  input  logic           rst,
  input  logic           control,
  input  logic [7:0]     dll,
  input  logic [7:0]     dlh,
  input  logic [1:0]     word_len,
  input  logic           parity_en,
  input  logic           even_parity,
  input  logic           rx_in,
  uart_rx_core_if.master rbr
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall;
  logic                   ctrl_q;
  logic [DIV_W-1:0]       div_q, cnt_q;
  logic                   tick;
  logic [3:0]             sc_q, sc_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             data_q, data_d;
  logic                   commit;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d, parity_err_q;
`else
  logic                   unused_par;
  assign unused_par = parity_en ^ even_parity;
`endif

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;
  assign tick = ~control && (div_q != '0) && (cnt_q == div_q - DIV_W'(1));

  // Synchronizer and edge-detect flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      ctrl_q <= 1'b0;
      div_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= control;
      if (ctrl_q && !control)
        div_q <= DIV_W'({dlh, dll});
      if (control || tick || (div_q == '0))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      data_q  <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (control) begin
      state_d = IDLE;
      sc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall && (div_q != '0)) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        START: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd7) begin
              sc_d = '0;
              if (!rx_s) begin
                state_d = DATA;
                bit_d   = '0;
                data_d  = '0;
`ifdef UART_RX_PARITY_EN
                perr_d  = 1'b0;
`endif
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        DATA: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd15) begin
              data_d[bit_q] = rx_s;
              bit_d         = bit_q + 3'd1;
              // Last index is word_len+4, i.e. {1, word_len}.
              if (bit_q == {1'b1, word_len}) begin
`ifdef UART_RX_PARITY_EN
                state_d = parity_en ? PARITY : STOP;
`else
                state_d = STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd15) begin
              perr_d  = (^data_q) ^ rx_s ^ ~even_parity;
              state_d = STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == 4'd15) begin
              commit  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit beats a same-cycle ack; an ack always clears the sticky overrun.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else if (commit) begin
      rx_data_q    <= data_q;
      rx_valid_q   <= 1'b1;
      frame_err_q  <= ~rx_s;
      overrun_q    <= (overrun_q | rx_valid_q) & ~rbr.rx_ack;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= perr_q;
`endif
    end else if (rbr.rx_ack) begin
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end
  end

  assign rbr.rx_data     = rx_data_q;
  assign rbr.rx_valid    = rx_valid_q;
  assign rbr.frame_err   = frame_err_q;
  assign rbr.overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rbr.parity_err  = parity_err_q;
`else
  assign rbr.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed serial frames at div=4 (64 clk/bit).
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int BIT = 64;

  logic       clk_cpu = 1'b0;
  logic       rst = 1'b0;
  logic       control = 1'b1;
  logic [7:0] dll = 8'd4;
  logic [7:0] dlh = 8'd0;
  logic [1:0] word_len = 2'b11;
  logic       parity_en = 1'b0;
  logic       even_parity = 1'b0;
  logic       rx_in = 1'b1;

  uart_rx_core_if bus ();

  uart_rx_core #(.SYNC_STAGES(2), .DIV_W(16)) dut (
    .clk_cpu     (clk_cpu),
    .rst         (rst),
    .control     (control),
    .dll         (dll),
    .dlh         (dlh),
    .word_len    (word_len),
    .parity_en   (parity_en),
    .even_parity (even_parity),
    .rx_in       (rx_in),
    .rbr         (bus)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       ovr;
    int         start;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a new output is a rising rx_valid or a changed byte/flag set while valid stays high.
  logic        pv = 1'b0;
  logic [10:0] pcur = '0;
  logic [10:0] cur;
  exp_t        me;
  int          lat;

  always @(negedge clk_cpu) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      cur = {bus.rx_data, bus.frame_err, bus.parity_err, bus.overrun_err};
      if (bus.rx_valid && (!pv || cur != pcur)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: rx_data=0x%0h frame_err=%0b parity_err=%0b overrun_err=%0b, none expected",
                   bus.rx_data, bus.frame_err, bus.parity_err, bus.overrun_err);
        end else begin
          me = exp_q.pop_front();
          chk("rx_data", bus.rx_data, me.data);
          chk("frame_err", 8'(bus.frame_err), 8'(me.ferr));
          chk("parity_err", 8'(bus.parity_err), 8'(me.perr));
          chk("overrun_err", 8'(bus.overrun_err), 8'(me.ovr));
          lat = cyc - me.start;
          checks++;
          if (lat < me.lat - 1 || lat > me.lat + 5) begin
            errors++;
            $display("FAIL latency: rx_valid %0d clk after start edge, expected %0d..%0d",
                     lat, me.lat - 1, me.lat + 5);
          end
        end
      end
      pv   = bus.rx_valid;
      pcur = cur;
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT) @(posedge clk_cpu);
    #1;
  endtask

  task automatic program_div(input logic [7:0] d);
    control = 1'b1;
    dll = d;
    dlh = 8'd0;
    repeat (3) @(posedge clk_cpu);
    #1 control = 1'b0;
    repeat (8) @(posedge clk_cpu);
    #1;
  endtask

  // Stop-bit mid-sample sits (1 + nbits + parity) bits plus half a bit after the start edge.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_on, input bit par_bit,
                            input bit stop_bit, input bit exp_perr, input bit exp_ovr);
    exp_t e;
    e.data  = d;
    e.ferr  = ~stop_bit;
    e.perr  = exp_perr;
    e.ovr   = exp_ovr;
    e.start = cyc;
    e.lat   = (nbits + (par_on ? 2 : 1)) * BIT + BIT / 2;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par_on) drive_bit(par_bit);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_cpu);
      n++;
    end
    @(posedge clk_cpu);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_ack();
    chk("valid_before_ack", 8'(bus.rx_valid), 8'd1);
    bus.rx_ack = 1'b1;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    chk("valid_after_ack", 8'(bus.rx_valid), 8'd0);
    chk("overrun_after_ack", 8'(bus.overrun_err), 8'd0);
    bus.rx_ack = 1'b0;
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_valid"}, 8'(bus.rx_valid), 8'd0);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_frame_err"}, 8'(bus.frame_err), 8'd0);
    chk({tag, "_parity_err"}, 8'(bus.parity_err), 8'd0);
    chk({tag, "_overrun_err"}, 8'(bus.overrun_err), 8'd0);
  endtask

  initial begin
    bus.rx_ack = 1'b0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk_cpu);
    #1 rst = 1'b0;
    program_div(8'd4);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();

    // 5-bit word 0x1F, upper bits zero
    word_len = 2'b00;
    drive_bit(1'b1);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();
    word_len = 2'b11;

    // 20-clk glitch: false start, then a normal frame still decodes
    rx_in = 1'b0;
    repeat (20) @(posedge clk_cpu);
    #1 rx_in = 1'b1;
    repeat (200) @(posedge clk_cpu);
    #1 chk("glitch_no_valid", 8'(bus.rx_valid), 8'd0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();

    // Overrun: two frames without ack
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain(200);
    chk("overrun_held", 8'(bus.overrun_err), 8'd1);
    do_ack();

    // Stop bit low
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();

    // Break: line low for two frame times -> exactly one commit of 0x00 with frame_err
    begin
      exp_t e;
      e.data = 8'h00; e.ferr = 1'b1; e.perr = 1'b0; e.ovr = 1'b0;
      e.start = cyc; e.lat = 9 * BIT + BIT / 2;
      exp_q.push_back(e);
    end
    rx_in = 1'b0;
    repeat (20 * BIT) @(posedge clk_cpu);
    #1 rx_in = 1'b1;
    repeat (3 * BIT) @(posedge clk_cpu);
    #1;
    wait_drain(50);
    do_ack();
    drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    // 8E1 0x07 (three ones): parity bit 0 is wrong, 1 is right
    parity_en = 1'b1;
    even_parity = 1'b1;
    send_frame(8'h07, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain(200);
    do_ack();
    send_frame(8'h07, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();
    parity_en = 1'b0;
    even_parity = 1'b0;
`endif

    // Reset mid-frame with a byte pending: outputs clear at once, next frame is clean
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    rx_in = 1'b0;
    repeat (100) @(posedge clk_cpu);
    #1 rst = 1'b1;
    #1 check_all_zero("midframe_rst");
    rx_in = 1'b1;
    repeat (3) @(posedge clk_cpu);
    #1 rst = 1'b0;
    program_div(8'd4);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    do_ack();

    repeat (2 * BIT) @(posedge clk_cpu);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
